io_handover_ctrl: RTL
=====================

# io_handover_ctrl

Controller that shares a group of user GPIO pads between the SoC core's peripherals and a Wishbone-driven host (management firmware test/bring-up mode). It owns the pad-side `io_out`/`io_oeb` for the group, exposes a small Wishbone register file, and sequences every ownership change through a tristated guard interval so the two drivers never fight on a pad. It sits in `user_project_wrapper` between `soc_core` pad pins and the top-level `io_*` ports.

## Interface
- `NPADS`, 24: pads in the shared group (1..32).
- `BASE_ADR`, 32'h3000_0000: Wishbone base; decode is `wbs_adr_i[31:5] == BASE_ADR[31:5]`.
- `GUARD_DEF`, 8'd4: reset value of the guard-cycle field.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone classic strobe/cycle/write.
- `wbs_sel_i` in 4: byte enables for writes.
- `wbs_adr_i`, `wbs_dat_i` in 32: address and write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data; 0 when not acking.
- `core_out`, `core_oeb` in NPADS: pad drive and active-low output enable from `soc_core`.
- `pad_in` in NPADS: from `io_in`.
- `pad_out`, `pad_oeb` out NPADS: to `io_out`/`io_oeb`.
- `core_hold` out 1: high whenever the core does not own the pads.
- `handover_irq` out 1: one-cycle pulse when a handover completes.

## Operation
- Registers, word-indexed by `wbs_adr_i[4:2]`:
  - 0 CTRL (RW): bit0 `req_host`; bits[15:8] `guard`. Reset: `req_host`=0, `guard`=GUARD_DEF.
  - 1 HOST_OUT (RW), bits[NPADS-1:0]. Reset 0.
  - 2 HOST_OEB (RW), bits[NPADS-1:0]. Reset all ones.
  - 3 STATUS (RO): bits[1:0] state code; bit2 = owner is host.
  - 4 PAD_IN (RO): `pad_in` after a 2-flop synchronizer.
  - Indices 5–7 read 0 and ignore writes. Unused bits read 0.
- Writes honour `wbs_sel_i` per byte. Writes to RO registers are acked and ignored.
- Access rules:
  - Ack is registered: asserted the cycle after `stb&cyc&match` is seen while ack is low, and held for exactly one cycle.
  - A held strobe therefore acks every other cycle.
  - Addresses outside the decode range are never acked.
- FSM states and codes: CORE=0, DRAIN_H=1, HOST=2, DRAIN_C=3.
  - CORE: when `req_host`=1, go to DRAIN_H and load `cnt`=`guard`.
  - DRAIN_H:
    - If `req_host`=0, go to DRAIN_C and reload `cnt`=`guard`.
    - Else if `cnt`=0, go to HOST and pulse `handover_irq`.
    - Else decrement `cnt`.
  - HOST: when `req_host`=0, go to DRAIN_C and load `cnt`=`guard`.
  - DRAIN_C: mirror of DRAIN_H. If `req_host`=1, go to DRAIN_H and reload. If `cnt`=0, go to CORE and pulse `handover_irq`.
  - `guard` is sampled only at load. Changing it mid-drain does not affect the current drain.
- Pad mux, combinational from the registered state:
  - CORE: `pad_out`=`core_out`, `pad_oeb`=`core_oeb`.
  - DRAIN_*: `pad_out`=0, `pad_oeb`=all ones.
  - HOST: `pad_out`=HOST_OUT, `pad_oeb`=HOST_OEB.
- `core_hold` = (state != CORE).

## Timing
- Reset values:
  - state=CORE, so `pad_out`/`pad_oeb` follow the core immediately.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `handover_irq`=0, synchronizer flops 0.
- A CTRL write that sets `req_host` takes effect on the ack edge. State is DRAIN_H on the following edge.
- Drain length is `guard`+1 cycles with all pads tristated. `guard`=0 gives exactly 1 cycle.
- `handover_irq` is high in the first cycle of the new owner state.
- PAD_IN latency: 2 cycles after a pad change, then readable on the next access.
- Reset asserted mid-drain or in HOST: state is CORE asynchronously and all registers return to reset values.

## Test plan
- Reset, then read all registers:
  - CTRL=0x0000_0400 (GUARD_DEF=4), HOST_OEB=0x00FF_FFFF, STATUS=0.
  - `pad_oeb` tracks `core_oeb`.
- Write HOST_OUT=0xA5, HOST_OEB=0xFFFF00, then CTRL=0x0000_0201:
  - exactly 3 cycles of `pad_oeb`=all ones;
  - then `pad_out[7:0]`=0xA5, `pad_oeb[7:0]`=0;
  - `handover_irq` is a single pulse; STATUS=0x6.
- From HOST, write CTRL=0x0000_0000: 1 drain cycle, then CORE; `core_hold` falls and `handover_irq` pulses.
- Set `req_host`=1 with `guard`=8, then clear it 3 cycles into DRAIN_H:
  - the FSM enters DRAIN_C and never reaches HOST;
  - CORE is reached after 9 further tristated cycles;
  - exactly one `handover_irq`.
- Bus checks:
  - access to BASE_ADR+0x20: no ack within 10 cycles;
  - byte write with sel=4'b0010 to CTRL changes only `guard`;
  - a held strobe gives alternating ack.
- Assert `wb_rst_i` asynchronously mid-HOST: pads return to core drive without waiting for a clock edge.

Source files
------------

// File: rtl/io_handover_ctrl_if.sv
// Wishbone classic slave bundle for io_handover_ctrl.
//   master : drives stb/cyc/we/sel/adr/dat_i, receives ack/dat_o
//   slave  : the register block (io_handover_ctrl)
interface io_handover_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/io_handover_ctrl.sv
// io_handover_ctrl
// Shares a group of NPADS user pads between soc_core and a Wishbone host.
// Every ownership change passes through a guard interval with all pads
// tristated so the two drivers never overlap.
// Ports:
//   wb_clk_i, wb_rst_i      : clock, async active-high reset
//   wb (slave modport)      : Wishbone classic register access
//   core_out/core_oeb       : pad drive / active-low enable from soc_core
//   pad_in                  : raw io_in from the pads
//   pad_out/pad_oeb         : muxed drive to io_out/io_oeb
//   core_hold               : high while the core does not own the pads
//   handover_irq            : one-cycle pulse when a handover completes
// Registers (word index adr[4:2]):
//   0 CTRL {guard[15:8], req_host[0]}, 1 HOST_OUT, 2 HOST_OEB,
//   3 STATUS {owner_is_host, state[1:0]}, 4 PAD_IN (synchronized)
module io_handover_ctrl #(
    parameter int          NPADS     = 24,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter logic [7:0]  GUARD_DEF = 8'd4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    io_handover_ctrl_if.slave wb,
    input  logic [NPADS-1:0] core_out,
    input  logic [NPADS-1:0] core_oeb,
    input  logic [NPADS-1:0] pad_in,
    output logic [NPADS-1:0] pad_out,
    output logic [NPADS-1:0] pad_oeb,
    output logic             core_hold,
    output logic             handover_irq
);

    typedef enum logic [1:0] {
        S_CORE    = 2'd0,
        S_DRAIN_H = 2'd1,
        S_HOST    = 2'd2,
        S_DRAIN_C = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic             r_irq;
    logic             r_req;
    logic [7:0]       r_guard;
    logic [NPADS-1:0] r_host_out;
    logic [NPADS-1:0] r_host_oeb;
    logic [NPADS-1:0] r_sync1;
    logic [NPADS-1:0] r_sync2;
    logic             r_ack;
    logic [31:0]      r_dat;

    logic             w_match;
    logic             w_acc;
    logic             w_wr;
    logic [2:0]       w_idx;
    logic             w_req_new;
    logic [7:0]       w_guard_new;
    logic [NPADS-1:0] w_hout_new;
    logic [NPADS-1:0] w_hoeb_new;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_match = (wb.wbs_adr_i[31:5] == BASE_ADR[31:5]);
    // Gating on ~r_ack makes a held strobe ack every other cycle.
    assign w_acc   = wb.wbs_stb_i & wb.wbs_cyc_i & w_match & ~r_ack;
    assign w_wr    = w_acc & wb.wbs_we_i;
    assign w_idx   = wb.wbs_adr_i[4:2];
    assign w_unused = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i};

    // Byte-lane merged write values
    always_comb begin
        w_req_new   = r_req;
        w_guard_new = r_guard;
        if (wb.wbs_sel_i[0]) w_req_new   = wb.wbs_dat_i[0];
        if (wb.wbs_sel_i[1]) w_guard_new = wb.wbs_dat_i[15:8];
    end

    for (genvar i = 0; i < NPADS; i++) begin : g_merge
        assign w_hout_new[i] = wb.wbs_sel_i[i/8] ? wb.wbs_dat_i[i] : r_host_out[i];
        assign w_hoeb_new[i] = wb.wbs_sel_i[i/8] ? wb.wbs_dat_i[i] : r_host_oeb[i];
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            3'd0:    w_rdata = {16'd0, r_guard, 7'd0, r_req};
            3'd1:    w_rdata = 32'(r_host_out);
            3'd2:    w_rdata = 32'(r_host_oeb);
            3'd3:    w_rdata = {29'd0, (r_state == S_HOST), r_state};
            3'd4:    w_rdata = 32'(r_sync2);
            default: w_rdata = 32'd0;
        endcase
    end

    // Bus side: ack/read data registered, writes land on the ack edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= 32'd0;
            r_req      <= 1'b0;
            r_guard    <= GUARD_DEF;
            r_host_out <= '0;
            r_host_oeb <= '1;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : 32'd0;
            if (w_wr) begin
                case (w_idx)
                    3'd0: begin
                        r_req   <= w_req_new;
                        r_guard <= w_guard_new;
                    end
                    3'd1:    r_host_out <= w_hout_new;
                    3'd2:    r_host_oeb <= w_hoeb_new;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    // Ownership FSM. cnt counts guard..0, so a drain lasts guard+1 cycles.
    // A request flip during a drain restarts the opposite drain in full.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_CORE;
            r_cnt   <= 8'd0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                S_CORE: begin
                    if (r_req) begin
                        r_state <= S_DRAIN_H;
                        r_cnt   <= r_guard;
                    end
                end
                S_DRAIN_H: begin
                    if (!r_req) begin
                        r_state <= S_DRAIN_C;
                        r_cnt   <= r_guard;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= S_HOST;
                        r_irq   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOST: begin
                    if (!r_req) begin
                        r_state <= S_DRAIN_C;
                        r_cnt   <= r_guard;
                    end
                end
                S_DRAIN_C: begin
                    if (r_req) begin
                        r_state <= S_DRAIN_H;
                        r_cnt   <= r_guard;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= S_CORE;
                        r_irq   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_CORE;
            endcase
        end
    end

    // Pad mux straight off the state flop so reset reclaims the pads at once
    always_comb begin
        pad_out = '0;
        pad_oeb = '1;
        case (r_state)
            S_CORE: begin
                pad_out = core_out;
                pad_oeb = core_oeb;
            end
            S_HOST: begin
                pad_out = r_host_out;
                pad_oeb = r_host_oeb;
            end
            default: begin
                pad_out = '0;
                pad_oeb = '1;
            end
        endcase
    end

    assign core_hold    = (r_state != S_CORE);
    assign handover_irq = r_irq;
    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;

endmodule
